// File: rtl/axi_lite_req_arbiter.sv
// Two-requester AXI-Lite arbiter: independent round-robin write and read paths, one outstanding per direction.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module axi_lite_req_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [RESP_WIDTH-1:0]   s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [1:0]              wr_grant,
  output logic [1:0]              rd_grant
);

  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_TOUT} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_TOUT} rd_state_t;

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;
  logic [1:0] r_wr_grant, w_wr_grant_nxt, r_rd_grant, w_rd_grant_nxt;
  logic       r_wr_ptr, w_wr_ptr_nxt, r_rd_ptr, w_rd_ptr_nxt;
  logic       r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
  logic       w_wsel, w_rsel, w_aw_hs, w_w_hs, w_awrdy, w_wrdy, w_bvld, w_arrdy, w_rvld;
  logic [RESP_WIDTH-1:0] w_bresp, w_rresp;
  logic [DATA_WIDTH-1:0] w_rdata;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wcnt, w_wcnt_nxt, r_rcnt, w_rcnt_nxt;
  logic             r_wdrain, w_wdrain_nxt, r_rdrain, w_rdrain_nxt;
`endif

  assign w_wsel   = r_wr_grant[1];
  assign w_rsel   = r_rd_grant[1];
  assign wr_grant = r_wr_grant;
  assign rd_grant = r_rd_grant;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
      r_wr_grant <= '0;
      r_rd_grant <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_wdrain   <= 1'b0;
      r_rdrain   <= 1'b0;
`endif
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_rd_grant <= w_rd_grant_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
`ifdef ARB_TIMEOUT_EN
      r_wcnt     <= w_wcnt_nxt;
      r_rcnt     <= w_rcnt_nxt;
      r_wdrain   <= w_wdrain_nxt;
      r_rdrain   <= w_rdrain_nxt;
`endif
    end
  end

  // Write path; AW and W completions are latched separately so each valid drops once accepted.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_grant_nxt = r_wr_grant;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    m_axi_awaddr   = '0;
    m_axi_awvalid  = 1'b0;
    m_axi_wdata    = '0;
    m_axi_wstrb    = '0;
    m_axi_wvalid   = 1'b0;
    m_axi_bready   = 1'b0;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    w_awrdy        = 1'b0;
    w_wrdy         = 1'b0;
    w_bvld         = 1'b0;
    w_bresp        = '0;
`ifdef ARB_TIMEOUT_EN
    w_wcnt_nxt     = '0;
    w_wdrain_nxt   = r_wdrain;
`endif
    case (r_wr_state)
      W_IDLE: begin
        if (s0_axi_awvalid || s1_axi_awvalid) begin
          if (s0_axi_awvalid && s1_axi_awvalid)
            w_wr_grant_nxt = r_wr_ptr ? 2'b10 : 2'b01;
          else
            w_wr_grant_nxt = s1_axi_awvalid ? 2'b10 : 2'b01;
          w_wr_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        m_axi_awaddr  = w_wsel ? s1_axi_awaddr : s0_axi_awaddr;
        m_axi_awvalid = (w_wsel ? s1_axi_awvalid : s0_axi_awvalid) && !r_aw_done;
        m_axi_wdata   = w_wsel ? s1_axi_wdata : s0_axi_wdata;
        m_axi_wstrb   = w_wsel ? s1_axi_wstrb : s0_axi_wstrb;
        m_axi_wvalid  = (w_wsel ? s1_axi_wvalid : s0_axi_wvalid) && !r_w_done;
        w_awrdy       = m_axi_awready && !r_aw_done;
        w_wrdy        = m_axi_wready && !r_w_done;
        w_aw_hs       = m_axi_awvalid && m_axi_awready;
        w_w_hs        = m_axi_wvalid && m_axi_wready;
        w_aw_done_nxt = r_aw_done || w_aw_hs;
        w_w_done_nxt  = r_w_done || w_w_hs;
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        w_bvld       = m_axi_bvalid;
        w_bresp      = m_axi_bresp;
        m_axi_bready = w_wsel ? s1_axi_bready : s0_axi_bready;
        if (m_axi_bvalid && m_axi_bready) begin
          w_wr_ptr_nxt   = !w_wsel;
          w_wr_grant_nxt = '0;
          w_wr_state_nxt = W_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
          if (!m_axi_bvalid && r_wcnt == CNT_W'(TIMEOUT_CYCLES - 1))
            w_wr_state_nxt = W_TOUT;
        end
`endif
      end
      default: begin
`ifdef ARB_TIMEOUT_EN
        w_bvld  = 1'b1;
        w_bresp = RESP_SLVERR;
        if (w_wsel ? s1_axi_bready : s0_axi_bready) begin
          w_wr_ptr_nxt   = !w_wsel;
          w_wr_grant_nxt = '0;
          w_wr_state_nxt = W_IDLE;
          w_wdrain_nxt   = 1'b1;
        end
`else
        w_wr_state_nxt = W_IDLE;
`endif
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    // Swallow a response that shows up after its transaction was already timed out.
    if (r_wdrain && (r_wr_state == W_IDLE || r_wr_state == W_ADDR)) begin
      m_axi_bready = 1'b1;
      if (m_axi_bvalid) w_wdrain_nxt = 1'b0;
    end
`endif
    s0_axi_awready = !w_wsel && w_awrdy;
    s1_axi_awready = w_wsel && w_awrdy;
    s0_axi_wready  = !w_wsel && w_wrdy;
    s1_axi_wready  = w_wsel && w_wrdy;
    s0_axi_bvalid  = !w_wsel && w_bvld;
    s1_axi_bvalid  = w_wsel && w_bvld;
    s0_axi_bresp   = w_wsel ? '0 : w_bresp;
    s1_axi_bresp   = w_wsel ? w_bresp : '0;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_grant_nxt = r_rd_grant;
    w_rd_ptr_nxt   = r_rd_ptr;
    m_axi_araddr   = '0;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    w_arrdy        = 1'b0;
    w_rvld         = 1'b0;
    w_rresp        = '0;
    w_rdata        = '0;
`ifdef ARB_TIMEOUT_EN
    w_rcnt_nxt     = '0;
    w_rdrain_nxt   = r_rdrain;
`endif
    case (r_rd_state)
      R_IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          if (s0_axi_arvalid && s1_axi_arvalid)
            w_rd_grant_nxt = r_rd_ptr ? 2'b10 : 2'b01;
          else
            w_rd_grant_nxt = s1_axi_arvalid ? 2'b10 : 2'b01;
          w_rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        m_axi_araddr  = w_rsel ? s1_axi_araddr : s0_axi_araddr;
        m_axi_arvalid = w_rsel ? s1_axi_arvalid : s0_axi_arvalid;
        w_arrdy       = m_axi_arready;
        if (m_axi_arvalid && m_axi_arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        w_rvld       = m_axi_rvalid;
        w_rresp      = m_axi_rresp;
        w_rdata      = m_axi_rdata;
        m_axi_rready = w_rsel ? s1_axi_rready : s0_axi_rready;
        if (m_axi_rvalid && m_axi_rready) begin
          w_rd_ptr_nxt   = !w_rsel;
          w_rd_grant_nxt = '0;
          w_rd_state_nxt = R_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
          if (!m_axi_rvalid && r_rcnt == CNT_W'(TIMEOUT_CYCLES - 1))
            w_rd_state_nxt = R_TOUT;
        end
`endif
      end
      default: begin
`ifdef ARB_TIMEOUT_EN
        w_rvld  = 1'b1;
        w_rresp = RESP_SLVERR;
        if (w_rsel ? s1_axi_rready : s0_axi_rready) begin
          w_rd_ptr_nxt   = !w_rsel;
          w_rd_grant_nxt = '0;
          w_rd_state_nxt = R_IDLE;
          w_rdrain_nxt   = 1'b1;
        end
`else
        w_rd_state_nxt = R_IDLE;
`endif
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    if (r_rdrain && (r_rd_state == R_IDLE || r_rd_state == R_ADDR)) begin
      m_axi_rready = 1'b1;
      if (m_axi_rvalid) w_rdrain_nxt = 1'b0;
    end
`endif
    s0_axi_arready = !w_rsel && w_arrdy;
    s1_axi_arready = w_rsel && w_arrdy;
    s0_axi_rvalid  = !w_rsel && w_rvld;
    s1_axi_rvalid  = w_rsel && w_rvld;
    s0_axi_rresp   = w_rsel ? '0 : w_rresp;
    s1_axi_rresp   = w_rsel ? w_rresp : '0;
    s0_axi_rdata   = w_rsel ? '0 : w_rdata;
    s1_axi_rdata   = w_rsel ? w_rdata : '0;
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed self-checking bench for axi_lite_req_arbiter; the timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_axi_lite_req_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] s0_awaddr = '0, s1_awaddr = '0, s0_araddr = '0, s1_araddr = '0;
  logic s0_awvalid = 0, s1_awvalid = 0, s0_wvalid = 0, s1_wvalid = 0;
  logic s0_bready = 0, s1_bready = 0, s0_arvalid = 0, s1_arvalid = 0, s0_rready = 0, s1_rready = 0;
  logic [DW-1:0] s0_wdata = '0, s1_wdata = '0;
  logic [DW/8-1:0] s0_wstrb = '0, s1_wstrb = '0;
  logic s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
  logic s0_arready, s1_arready, s0_rvalid, s1_rvalid;
  logic [RW-1:0] s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [RW-1:0] m_bresp = '0, m_rresp = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0] wr_grant, rd_grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s0_axi_awaddr(s0_awaddr), .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(s0_awready),
    .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready),
    .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s0_bready),
    .s0_axi_araddr(s0_araddr), .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
    .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s0_rready),
    .s1_axi_awaddr(s1_awaddr), .s1_axi_awvalid(s1_awvalid), .s1_axi_awready(s1_awready),
    .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(s1_wready),
    .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid), .s1_axi_bready(s1_bready),
    .s1_axi_araddr(s1_araddr), .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(s1_arready),
    .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp), .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s1_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    settle();
    chk("rst_wr_grant", 64'(wr_grant), 64'h0);
    chk("rst_rd_grant", 64'(rd_grant), 64'h0);
    chk("rst_m_awvalid", 64'(m_awvalid), 64'h0);
    chk("rst_m_bready", 64'(m_bready), 64'h0);
    rst = 1'b0;
    step();

    // Single write from s0
    s0_awaddr = 8'h04; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
    s0_awvalid = 1; s0_wvalid = 1;
    settle();
    chk("t1_bubble_awvalid", 64'(m_awvalid), 64'h0);
    step();
    chk("t1_wr_grant", 64'(wr_grant), 64'h1);
    chk("t1_m_awaddr", 64'(m_awaddr), 64'h04);
    chk("t1_m_wdata", 64'(m_wdata), 64'hDEADBEEF);
    chk("t1_m_awvalid", 64'(m_awvalid), 64'h1);
    m_awready = 1; m_wready = 1;
    settle();
    chk("t1_s0_awready", 64'(s0_awready), 64'h1);
    chk("t1_s1_awready", 64'(s1_awready), 64'h0);
    step();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = 2'd0; s0_bready = 1;
    settle();
    chk("t1_s0_bvalid", 64'(s0_bvalid), 64'h1);
    chk("t1_s0_bresp", 64'(s0_bresp), 64'h0);
    chk("t1_s1_bvalid", 64'(s1_bvalid), 64'h0);
    chk("t1_m_bready", 64'(m_bready), 64'h1);
    step();
    m_bvalid = 0; s0_bready = 0;
    settle();
    chk("t1_idle_grant", 64'(wr_grant), 64'h0);

    // Simultaneous requesters alternate starting from s0
    do_reset();
    s0_awaddr = 8'h08; s1_awaddr = 8'h0C;
    s0_awvalid = 1; s1_awvalid = 1; s0_wvalid = 1; s1_wvalid = 1;
    m_awready = 1; m_wready = 1; m_bvalid = 1; s0_bready = 1; s1_bready = 1;
    step();
    chk("t2_first_grant", 64'(wr_grant), 64'h1);
    chk("t2_first_addr", 64'(m_awaddr), 64'h08);
    chk("t2_s1_awready", 64'(s1_awready), 64'h0);
    step();
    chk("t2_s0_bvalid", 64'(s0_bvalid), 64'h1);
    chk("t2_s1_bvalid", 64'(s1_bvalid), 64'h0);
    step();
    chk("t2_gap_grant", 64'(wr_grant), 64'h0);
    step();
    chk("t2_second_grant", 64'(wr_grant), 64'h2);
    chk("t2_second_addr", 64'(m_awaddr), 64'h0C);
    step();
    step();
    step();
    chk("t2_third_grant", 64'(wr_grant), 64'h1);
    step();
    step();
    s0_awvalid = 0; s1_awvalid = 0; s0_wvalid = 0; s1_wvalid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; s0_bready = 0; s1_bready = 0;
    step();
    chk("t2_end_grant", 64'(wr_grant), 64'h0);

    // Concurrent s0 write and s1 read
    s0_awaddr = 8'h10; s0_awvalid = 1; s0_wvalid = 1;
    s1_araddr = 8'h18; s1_arvalid = 1;
    step();
    chk("t3_wr_grant", 64'(wr_grant), 64'h1);
    chk("t3_rd_grant", 64'(rd_grant), 64'h2);
    chk("t3_m_araddr", 64'(m_araddr), 64'h18);
    chk("t3_m_awaddr", 64'(m_awaddr), 64'h10);
    m_awready = 1; m_wready = 1; m_arready = 1;
    step();
    s0_awvalid = 0; s0_wvalid = 0; s1_arvalid = 0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = 32'h12345678; s1_rready = 1;
    m_bvalid = 1; s0_bready = 1;
    settle();
    chk("t3_s1_rdata", 64'(s1_rdata), 64'h12345678);
    chk("t3_s1_rvalid", 64'(s1_rvalid), 64'h1);
    chk("t3_s0_rvalid", 64'(s0_rvalid), 64'h0);
    chk("t3_s0_rdata", 64'(s0_rdata), 64'h0);
    chk("t3_s0_bvalid", 64'(s0_bvalid), 64'h1);
    step();
    m_rvalid = 0; m_bvalid = 0; s1_rready = 0; s0_bready = 0;
    settle();
    chk("t3_rd_idle", 64'(rd_grant), 64'h0);
    chk("t3_wr_idle", 64'(wr_grant), 64'h0);

    // W accepted two cycles ahead of AW
    s1_awaddr = 8'h20; s1_wdata = 32'hCAFEF00D; s1_awvalid = 1; s1_wvalid = 1;
    step();
    chk("t4_grant", 64'(wr_grant), 64'h2);
    m_wready = 1;
    settle();
    chk("t4_m_wvalid", 64'(m_wvalid), 64'h1);
    step();
    m_wready = 0;
    settle();
    chk("t4_w_masked", 64'(m_wvalid), 64'h0);
    chk("t4_aw_pending", 64'(m_awvalid), 64'h1);
    s1_wvalid = 0;
    step();
    chk("t4_still_granted", 64'(wr_grant), 64'h2);
    chk("t4_aw_still", 64'(m_awvalid), 64'h1);
    m_awready = 1;
    step();
    s1_awvalid = 0; m_awready = 0;
    settle();
    chk("t4_no_dup_aw", 64'(m_awvalid), 64'h0);
    m_bvalid = 1; m_bresp = 2'd2; s1_bready = 1;
    settle();
    chk("t4_s1_bvalid", 64'(s1_bvalid), 64'h1);
    chk("t4_s1_bresp", 64'(s1_bresp), 64'h2);
    step();
    m_bvalid = 0; m_bresp = 2'd0; s1_bready = 0;
    step();
    chk("t4_single_resp", 64'(s1_bvalid), 64'h0);
    chk("t4_idle_aw", 64'(m_awvalid), 64'h0);

    // Reset while waiting for the write response
    s0_awvalid = 1; s0_wvalid = 1; m_awready = 1; m_wready = 1;
    step();
    step();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1;
    settle();
    chk("t5_in_resp_grant", 64'(wr_grant), 64'h1);
    chk("t5_in_resp_bvalid", 64'(s0_bvalid), 64'h1);
    rst = 1'b1;
    settle();
    chk("t5_rst_grant", 64'(wr_grant), 64'h0);
    chk("t5_rst_bvalid", 64'(s0_bvalid), 64'h0);
    chk("t5_rst_bready", 64'(m_bready), 64'h0);
    m_bvalid = 0;
    step();
    rst = 1'b0;
    s0_awvalid = 1; s1_awvalid = 1;
    step();
    chk("t5_regrant_s0", 64'(wr_grant), 64'h1);
    s0_awvalid = 0; s1_awvalid = 0;
    do_reset();

`ifdef ARB_TIMEOUT_EN
    // Read watchdog: no downstream rvalid
    s0_araddr = 8'h30; s0_arvalid = 1; m_arready = 1; m_rdata = 32'hFFFFFFFF;
    step();
    chk("t6_rd_grant", 64'(rd_grant), 64'h1);
    step();
    s0_arvalid = 0; m_arready = 0;
    for (int i = 0; i < 7; i++) step();
    chk("t6_pre_timeout", 64'(s0_rvalid), 64'h0);
    step();
    chk("t6_rvalid", 64'(s0_rvalid), 64'h1);
    chk("t6_rresp", 64'(s0_rresp), 64'h2);
    chk("t6_rdata", 64'(s0_rdata), 64'h0);
    chk("t6_m_rready", 64'(m_rready), 64'h0);
    s0_rready = 1;
    step();
    s0_rready = 0;
    settle();
    chk("t6_idle", 64'(rd_grant), 64'h0);
    m_rvalid = 1;
    settle();
    chk("t6_drain_ready", 64'(m_rready), 64'h1);
    chk("t6_drain_hidden", 64'(s0_rvalid), 64'h0);
    step();
    m_rvalid = 0;
    settle();
    chk("t6_drain_done", 64'(m_rready), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
